rgb_pattern_gen: RTL and testbench

RGB_PATTERN_GEN -- requirements
Module: rgb_pattern_gen

---
 rtl/rgb_pattern_gen_if.sv | 25 ++
 rtl/rgb_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_rgb_pattern_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pattern_gen_if.sv
// Video bundle between the timing source / control side and rgb_pattern_gen.
// The master drives switches, mode and visible windows; the slave returns colour and data-enable.
interface rgb_pattern_gen_if #(
  parameter int COLOR_W = 4,
  parameter int SW_W    = 8
);
  logic [SW_W-1:0]    switch;
  logic [1:0]         mode;
  logic               h_visable;
  logic               v_visable;
  logic [COLOR_W-1:0] R;
  logic [COLOR_W-1:0] G;
  logic [COLOR_W-1:0] B;
  logic               de_out;

  modport master (
    output switch, mode, h_visable, v_visable,
    input  R, G, B, de_out
  );

  modport slave (
    input  switch, mode, h_visable, v_visable,
    output R, G, B, de_out
  );
endinterface

// File: rtl/rgb_pattern_gen.sv
// RGB test-pattern generator: solid, colour bars, checkerboard and inverted patterns, registered outputs.
// Optional frame blinking is added when the macro RGB_PATTERN_BLINK_EN is defined.
module rgb_pattern_gen #(
  parameter int COLOR_W  = 4,
  parameter int SW_W     = 8,
  parameter int H_ACTIVE = 640
) (
  input logic clk,
  input logic rst_n,
`ifdef RGB_PATTERN_BLINK_EN
  input logic blink,
`endif
  rgb_pattern_gen_if.slave vid
);

  localparam int XW     = ($clog2(H_ACTIVE) > 6) ? $clog2(H_ACTIVE) : 6;
  localparam int YW     = 11;
  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int SW_USE = (SW_W < 8) ? SW_W : 8;
  localparam int RGB_W  = 3 * COLOR_W;

  localparam logic [COLOR_W-1:0] LV_Z = '0;
  localparam logic [COLOR_W-1:0] LV_F = '1;
  localparam logic [COLOR_W-1:0] LV_H = COLOR_W'(1 << (COLOR_W - 1));
  localparam logic [COLOR_W-1:0] LV_Q = COLOR_W'(1 << (COLOR_W - 2));
  localparam logic [COLOR_W-1:0] LV_L = COLOR_W'(1);

  function automatic logic [RGB_W-1:0] paletteRgb(input logic [2:0] idx);
    logic [RGB_W-1:0] rgb;
    case (idx)
      3'd0:    rgb = {LV_Z, LV_Z, LV_Z};
      3'd1:    rgb = {LV_Z, LV_Z, LV_F};
      3'd2:    rgb = {LV_H, LV_Q, LV_L};
      3'd3:    rgb = {LV_Z, LV_H, LV_H};
      3'd4:    rgb = {LV_F, LV_Z, LV_Z};
      3'd5:    rgb = {LV_H, LV_Z, LV_H};
      3'd6:    rgb = {LV_F, LV_F, LV_Z};
      default: rgb = {LV_F, LV_F, LV_F};
    endcase
    return rgb;
  endfunction

  // Scanning from the top down leaves the lowest set bit as the winner.
  function automatic logic [2:0] lowestSetIdx(input logic [SW_W-1:0] sw);
    logic [2:0] idx;
    idx = '0;
    for (int i = SW_USE - 1; i >= 0; i--) begin
      if (sw[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [SW_W-1:0]  swMeta_q, swSync_q;
  logic             hPrev_q, vPrev_q, vArmed_q;
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             de_q, de_d;
  logic [RGB_W-1:0] baseRgb;
  logic [2:0]       barIdx;
  logic             active, vRise, hFall;

  // vArmed keeps a frame already in progress at reset release from looking like a new frame.
  assign active = vid.h_visable & vid.v_visable;
  assign vRise  = vid.v_visable & ~vPrev_q & vArmed_q;
  assign hFall  = hPrev_q & ~vid.h_visable;

  always_comb begin
    idx_d  = idx_q;
    mode_d = mode_q;
    if (vRise) begin
      idx_d  = lowestSetIdx(swSync_q);
      mode_d = vid.mode;
    end
  end

  always_comb begin
    x_d = x_q;
    if (!vid.h_visable) begin
      x_d = '0;
    end else if (vid.v_visable && (x_q != XW'(H_ACTIVE - 1))) begin
      x_d = x_q + XW'(1);
    end
  end

  always_comb begin
    y_d = y_q;
    if (!vid.v_visable) begin
      y_d = '0;
    end else if (hFall) begin
      y_d = y_q + YW'(1);
    end
  end

  always_comb begin
    barIdx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x_q >= XW'(k * BAR_W)) barIdx = 3'(k);
    end
  end

`ifdef RGB_PATTERN_BLINK_EN
  logic [4:0] frameCnt_q, frameCnt_d;

  always_comb begin
    frameCnt_d = frameCnt_q;
    if (vPrev_q && !vid.v_visable) frameCnt_d = frameCnt_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frameCnt_q <= '0;
    else        frameCnt_q <= frameCnt_d;
  end
`endif

  // Uses the just-latched index so the first pixel of a new frame already shows the new colour.
  assign baseRgb = paletteRgb(idx_d);

  always_comb begin
    rgb_d = '0;
    case (mode_d)
      2'd0:    rgb_d = baseRgb;
      2'd1:    rgb_d = paletteRgb(barIdx);
      2'd2:    rgb_d = (x_q[5] ^ y_q[5]) ? '0 : baseRgb;
      default: rgb_d = ~baseRgb;
    endcase
    if (!active) rgb_d = '0;
`ifdef RGB_PATTERN_BLINK_EN
    if (blink && frameCnt_q[4]) rgb_d = '0;
`endif
  end

  assign de_d = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swMeta_q <= '0;
      swSync_q <= '0;
      hPrev_q  <= 1'b0;
      vPrev_q  <= 1'b0;
      vArmed_q <= 1'b0;
      idx_q    <= '0;
      mode_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
    end else begin
      swMeta_q <= vid.switch;
      swSync_q <= swMeta_q;
      hPrev_q  <= vid.h_visable;
      vPrev_q  <= vid.v_visable;
      vArmed_q <= vArmed_q | ~vid.v_visable;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
    end
  end

  assign vid.R      = rgb_q[RGB_W-1 -: COLOR_W];
  assign vid.G      = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vid.B      = rgb_q[COLOR_W-1:0];
  assign vid.de_out = de_q;

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// Self-checking bench for rgb_pattern_gen: frame-level behavioural model compared every cycle,
// plus literal pixel expectations captured per frame.
module tb_rgb_pattern_gen;

  localparam int CW   = 4;
  localparam int SWW  = 8;
  localparam int HA   = 640;
  localparam int MAXY = 34;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  rgb_pattern_gen_if #(.COLOR_W(CW), .SW_W(SWW)) vid ();

  rgb_pattern_gen #(.COLOR_W(CW), .SW_W(SWW), .H_ACTIVE(HA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef RGB_PATTERN_BLINK_EN
    .blink (1'b0),
`endif
    .vid   (vid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [12:0] dutOut;
  assign dutOut = {vid.de_out, vid.R, vid.G, vid.B};

  function automatic int lowestBit(input logic [7:0] sw);
    for (int i = 0; i < 8; i++) begin
      if (sw[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [11:0] paletteColour(input int idx);
    case (idx)
      0: return 12'h000;
      1: return 12'h00F;
      2: return 12'h841;
      3: return 12'h088;
      4: return 12'hF00;
      5: return 12'h808;
      6: return 12'hFF0;
      7: return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [12:0] modelPixel(input int idx, input int md, input int x, input int y);
    int xs;
    logic [11:0] c;
    xs = (x > HA - 1) ? HA - 1 : x;
    case (md)
      0: c = paletteColour(idx);
      1: c = paletteColour(xs / (HA / 8));
      2: c = ((((xs / 32) + (y / 32)) % 2) == 0) ? paletteColour(idx) : 12'h000;
      default: c = 12'hFFF - paletteColour(idx);
    endcase
    return {1'b1, c};
  endfunction

  // Frame-level model: switch seen two samples late, settings taken at each new frame.
  logic [7:0]  mSwA, mSwB;
  logic        mPrevV, mPrevH;
  int          mX, mY, mIdx, mMode;
  logic [12:0] expOut;
  logic        expVis;
  int          expX, expY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSwA   <= 8'h00;
      mSwB   <= 8'h00;
      mPrevV <= 1'b1;
      mPrevH <= 1'b0;
      mX     <= 0;
      mY     <= 0;
      mIdx   <= 0;
      mMode  <= 0;
      expOut <= 13'h0;
      expVis <= 1'b0;
      expX   <= 0;
      expY   <= 0;
    end else begin
      mSwA   <= vid.switch;
      mSwB   <= mSwA;
      mPrevV <= vid.v_visable;
      mPrevH <= vid.h_visable;
      if (vid.v_visable && !mPrevV) begin
        mIdx   <= lowestBit(mSwB);
        mMode  <= int'(vid.mode);
        expOut <= (vid.h_visable && vid.v_visable) ?
                  modelPixel(lowestBit(mSwB), int'(vid.mode), mX, mY) : 13'h0;
      end else begin
        expOut <= (vid.h_visable && vid.v_visable) ? modelPixel(mIdx, mMode, mX, mY) : 13'h0;
      end
      mX     <= !vid.h_visable ? 0 : ((vid.h_visable && vid.v_visable) ? mX + 1 : mX);
      mY     <= !vid.v_visable ? 0 : ((mPrevH && !vid.h_visable) ? mY + 1 : mY);
      expVis <= vid.h_visable && vid.v_visable;
      expX   <= mX;
      expY   <= mY;
    end
  end

  logic [12:0] cap [0:MAXY-1][0:HA-1];

  task automatic checkOutput(input string name, input logic [12:0] actual, input logic [12:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual de/rgb=%h expected de/rgb=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkPixel(input string name, input int y, input int x, input logic [11:0] rgb);
    checkOutput(name, cap[y][x], {1'b1, rgb});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("pixel", dutOut, expOut);
      if (expVis && expY < MAXY && expX < HA) cap[expY][expX] = dutOut;
    end
  end

  // One frame: optional mid-frame input change, switch change at the frame edge, or mid-line reset.
  task automatic applyStimulus(input logic [7:0] sw, input logic [1:0] md, input int lines,
                               input int lineLen, input int midLine, input logic [7:0] swMid,
                               input logic [1:0] mdMid, input bit swAtEdge, input int resetAt);
    for (int yy = 0; yy < MAXY; yy++)
      for (int xx = 0; xx < HA; xx++)
        cap[yy][xx] = 13'h1FFF;
    @(negedge clk);
    vid.mode = md;
    if (!swAtEdge) vid.switch = sw;
    repeat (6) @(negedge clk);
    vid.v_visable = 1'b1;
    if (swAtEdge) vid.switch = sw;
    for (int l = 0; l < lines; l++) begin
      if (l == midLine) begin
        vid.switch = swMid;
        vid.mode   = mdMid;
      end
      for (int p = 0; p < lineLen; p++) begin
        @(negedge clk);
        vid.h_visable = 1'b1;
        if (l == 0 && p == resetAt) begin
          #2 rst_n = 1'b0;
          #1 checkOutput("reset_async", dutOut, 13'h0);
        end
        if (l == 0 && p == resetAt + 3) rst_n = 1'b1;
      end
      @(negedge clk);
      vid.h_visable = 1'b0;
      repeat (7) @(negedge clk);
    end
    @(negedge clk);
    vid.v_visable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: run did not finish, actual time %0t limit 5000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vid.switch    = 8'h00;
    vid.mode      = 2'd0;
    vid.h_visable = 1'b0;
    vid.v_visable = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", dutOut, 13'h0);
    rst_n = 1'b1;

    applyStimulus(8'b0000_0100, 2'd0, 2, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("solid_idx2", 1, 5, 12'h841);
    checkOutput("blanking", dutOut, 13'h0);

    applyStimulus(8'b1001_0000, 2'd0, 1, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("solid_idx4", 0, 100, 12'hF00);

    applyStimulus(8'b0000_0000, 2'd0, 1, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("solid_none", 0, 3, 12'h000);

    applyStimulus(8'b0000_0000, 2'd1, 1, HA + 10, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("bar0_first", 0, 0, 12'h000);
    checkPixel("bar0_last", 0, 79, 12'h000);
    checkPixel("bar1_first", 0, 80, 12'h00F);
    checkPixel("bar1_last", 0, 159, 12'h00F);
    checkPixel("bar2_first", 0, 160, 12'h841);
    checkPixel("bar7_first", 0, 560, 12'hFFF);
    checkPixel("bar7_last", 0, 639, 12'hFFF);

    applyStimulus(8'b1000_0000, 2'd2, MAXY, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("check_31_0", 0, 31, 12'hFFF);
    checkPixel("check_32_0", 0, 32, 12'h000);
    checkPixel("check_32_32", 32, 32, 12'hFFF);
    checkPixel("check_0_32", 32, 0, 12'h000);

    applyStimulus(8'b0000_0100, 2'd0, 3, HA, 1, 8'b0001_0000, 2'd3, 1'b0, -1);
    checkPixel("mid_change_hold", 2, 10, 12'h841);
    applyStimulus(8'b0001_0000, 2'd3, 1, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("next_frame_inv", 0, 0, 12'h0FF);

    applyStimulus(8'b0000_0010, 2'd0, 1, HA, -1, 8'h00, 2'd0, 1'b1, -1);
    checkPixel("edge_sync_old", 0, 5, 12'hF00);
    applyStimulus(8'b0000_0010, 2'd0, 1, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("edge_sync_new", 0, 5, 12'h00F);

    applyStimulus(8'b0000_0000, 2'd3, 1, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("inv_black", 0, 5, 12'hFFF);
    applyStimulus(8'b0000_0000, 2'd3, 1, HA, -1, 8'h00, 2'd0, 1'b0, 100);
    checkPixel("post_reset_idx0", 0, 10, 12'h000);
    applyStimulus(8'b0000_0000, 2'd3, 1, HA, -1, 8'h00, 2'd0, 1'b0, -1);
    checkPixel("post_reset_new_frame", 0, 10, 12'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
